// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl
// Latches rising edges on N request lines into a pending register, masks
// them, and presents the highest pending index (bit N-1 wins) through a
// valid/ack handshake. Each event stays pending until the consumer acks it.
// A new edge on a line that is still pending sets a sticky overrun flag.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_in     [N]  level request lines; a 0->1 transition is an event
//   mask_in    [N]  1 = line not eligible (still captured as pending)
//   ack        consumer accepts the presented index
//   clr_ovr    clears all overrun flags
//   out_valid  out_idx holds a presented index
//   out_idx    [IW] presented index, held until ack, kept in IDLE
//   pend_out   [N]  pending register
//   ovr_out    [N]  sticky overrun flags

// Per-line edge detect, pending bit and overrun flag.
module irq_pending_lane (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   input  logic clr,      // accepted ack of this line's index
   input  logic clr_ovr,
   output logic pend,
   output logic ovr
);
   logic req_q;
   logic rise;

   assign rise = req & ~req_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q <= 1'b0;
         pend  <= 1'b0;
         ovr   <= 1'b0;
      end else begin
         req_q <= req;
         // A new edge beats a simultaneous ack so the event is not lost.
         if (rise)     pend <= 1'b1;
         else if (clr) pend <= 1'b0;
         // A fresh overrun beats clr_ovr. An edge landing on the ack that
         // clears this bit is a collision, not an overrun.
         if (rise && pend && !clr) ovr <= 1'b1;
         else if (clr_ovr)         ovr <= 1'b0;
      end
   end
endmodule

module irq_pending_ctrl #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req_in,
   input  logic [N-1:0]  mask_in,
   input  logic          ack,
   input  logic          clr_ovr,
   output logic          out_valid,
   output logic [IW-1:0] out_idx,
   output logic [N-1:0]  pend_out,
   output logic [N-1:0]  ovr_out
);
   typedef enum logic {IDLE, PRESENT} state_t;

   state_t         state;
   logic [N-1:0]   elig;
   logic [N-1:0]   clr;
   logic [IW-1:0]  enc;
   logic           ack_acc;

   // ack only means something while an index is presented.
   assign ack_acc = (state == PRESENT) && ack;
   assign elig    = pend_out & ~mask_in;

   // Highest set bit wins: later iterations overwrite lower ones.
   always_comb begin
      enc = '0;
      for (int i = 0; i < N; i++)
         if (elig[i]) enc = IW'(i);
   end

   for (genvar g = 0; g < N; g++) begin : g_lane
      assign clr[g] = ack_acc && (out_idx == IW'(g));
      irq_pending_lane u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .req     (req_in[g]),
         .clr     (clr[g]),
         .clr_ovr (clr_ovr),
         .pend    (pend_out[g]),
         .ovr     (ovr_out[g])
      );
   end

   // Presentation FSM. out_idx is frozen in PRESENT: no preemption and
   // masking the presented line does not retract it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|elig) begin
                  out_idx   <= enc;
                  out_valid <= 1'b1;
                  state     <= PRESENT;
               end
            end
            PRESENT: begin
               if (ack) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_irq_pending_ctrl.sv
module tb_irq_pending_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req_in, mask_in;
   logic       ack, clr_ovr;
   logic       out_valid;
   logic [1:0] out_idx;
   logic [3:0] pend_out, ovr_out;

   int checks = 0;
   int errors = 0;
   int sb[$];   // expected presentation order

   irq_pending_ctrl #(.N(4), .IW(2)) dut (
      .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask_in(mask_in),
      .ack(ack), .clr_ovr(clr_ovr), .out_valid(out_valid),
      .out_idx(out_idx), .pend_out(pend_out), .ovr_out(ovr_out)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 12; n++) begin
         if (out_valid) begin ok = 1'b1; return; end
         step();
      end
   endtask

   task automatic test_reset();
      bit ok; int e;
      rst_n = 1'b0; req_in = 4'b1111; mask_in = 4'b0; ack = 1'b0; clr_ovr = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_idx, pend_out, ovr_out} !== 11'b0) begin
         errors++; $display("FAIL reset_outputs got %b want 0", {out_valid, out_idx, pend_out, ovr_out});
      end
      step(); step();
      checks++;
      if ({out_valid, pend_out} !== 5'b0) begin
         errors++; $display("FAIL reset_hold got v=%b p=%b want 0", out_valid, pend_out);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (pend_out !== 4'b1111 || out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_edge1 got p=%b v=%b want 1111/0", pend_out, out_valid);
      end
      req_in = 4'b0;
      sb.push_back(3); sb.push_back(2); sb.push_back(1); sb.push_back(0);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'd3) begin
         errors++; $display("FAIL reset_edge2 got v=%b idx=%0d want 1/3", out_valid, out_idx);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         wait_valid(ok);
         checks++;
         if (!ok || out_idx !== 2'(e)) begin
            errors++; $display("FAIL reset_drain got v=%b idx=%0d want idx %0d", out_valid, out_idx, e);
         end
         ack = 1'b1; step(); ack = 1'b0;
      end
      checks++;
      if (pend_out !== 4'b0) begin
         errors++; $display("FAIL reset_drain_pend got %b want 0000", pend_out);
      end
   endtask

   task automatic test_priority_drain();
      int e;
      req_in = 4'b0101; step(); req_in = 4'b0;
      sb.push_back(2); sb.push_back(0);
      step();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (out_valid !== 1'b1 || out_idx !== 2'(e)) begin
            errors++; $display("FAIL prio_idx got v=%b idx=%0d want 1/%0d", out_valid, out_idx, e);
         end
         ack = 1'b1; step(); ack = 1'b0;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL prio_bubble got v=%b want 0", out_valid);
         end
         step();
      end
      checks++;
      if (pend_out !== 4'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL prio_final got p=%b v=%b want 0000/0", pend_out, out_valid);
      end
   endtask

   task automatic test_no_preempt();
      bit ok; int e;
      req_in = 4'b0010; step(); req_in = 4'b0;
      sb.push_back(1); sb.push_back(3);
      step();
      req_in = 4'b1000; step(); req_in = 4'b0; step();
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'd1 || pend_out !== 4'b1010) begin
         errors++; $display("FAIL no_preempt got v=%b idx=%0d p=%b want 1/1/1010", out_valid, out_idx, pend_out);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         wait_valid(ok);
         checks++;
         if (!ok || out_idx !== 2'(e)) begin
            errors++; $display("FAIL no_preempt_order got v=%b idx=%0d want idx %0d", out_valid, out_idx, e);
         end
         ack = 1'b1; step(); ack = 1'b0;
      end
   endtask

   task automatic test_mask();
      int e;
      mask_in = 4'b1000; req_in = 4'b1000; step(); req_in = 4'b0;
      step(); step();
      checks++;
      if (pend_out !== 4'b1000 || out_valid !== 1'b0) begin
         errors++; $display("FAIL mask_hold got p=%b v=%b want 1000/0", pend_out, out_valid);
      end
      mask_in = 4'b0;
      sb.push_back(3);
      step();
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'(e)) begin
         errors++; $display("FAIL mask_release got v=%b idx=%0d want 1/%0d", out_valid, out_idx, e);
      end
      ack = 1'b1; step(); ack = 1'b0; step();
   endtask

   task automatic test_overrun();
      bit ok; int e;
      req_in = 4'b0001; step(); req_in = 4'b0;
      sb.push_back(0);
      step();
      req_in = 4'b0001; step(); req_in = 4'b0;
      checks++;
      if (ovr_out !== 4'b0001 || pend_out !== 4'b0001) begin
         errors++; $display("FAIL overrun_set got o=%b p=%b want 0001/0001", ovr_out, pend_out);
      end
      clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
      checks++;
      if (ovr_out !== 4'b0000) begin
         errors++; $display("FAIL overrun_clr got %b want 0000", ovr_out);
      end
      e = sb.pop_front();
      wait_valid(ok);
      checks++;
      if (!ok || out_idx !== 2'(e)) begin
         errors++; $display("FAIL overrun_idx got v=%b idx=%0d want idx %0d", out_valid, out_idx, e);
      end
      ack = 1'b1; step(); ack = 1'b0; step();
   endtask

   task automatic test_collision();
      bit ok; int e;
      req_in = 4'b0100; step(); req_in = 4'b0;
      sb.push_back(2); sb.push_back(2);
      step();
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'(e)) begin
         errors++; $display("FAIL coll_first got v=%b idx=%0d want 1/%0d", out_valid, out_idx, e);
      end
      ack = 1'b1; req_in = 4'b0100; step(); ack = 1'b0; req_in = 4'b0;
      checks++;
      if (pend_out !== 4'b0100 || ovr_out !== 4'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL coll_pend got p=%b o=%b v=%b want 0100/0000/0", pend_out, ovr_out, out_valid);
      end
      e = sb.pop_front();
      wait_valid(ok);
      checks++;
      if (!ok || out_idx !== 2'(e)) begin
         errors++; $display("FAIL coll_repeat got v=%b idx=%0d want idx %0d", out_valid, out_idx, e);
      end
      ack = 1'b1; step(); ack = 1'b0; step();
   endtask

   task automatic test_async_reset();
      req_in = 4'b0001; step(); req_in = 4'b0;
      sb.push_back(0);
      step();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL areset_pre got v=%b want 1", out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      sb.delete();   // presented index is discarded by reset
      checks++;
      if (out_valid !== 1'b0 || pend_out !== 4'b0) begin
         errors++; $display("FAIL areset_now got v=%b p=%b want 0/0000", out_valid, pend_out);
      end
      step(); rst_n = 1'b1;
      ack = 1'b1; step(); step(); ack = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || pend_out !== 4'b0 || ovr_out !== 4'b0 || sb.size() != 0) begin
         errors++; $display("FAIL areset_ack got v=%b p=%b o=%b want 0/0000/0000", out_valid, pend_out, ovr_out);
      end
   endtask

   initial begin
      test_reset();
      test_priority_drain();
      test_no_preempt();
      test_mask();
      test_overrun();
      test_collision();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
